// File: rtl/pow3_capture.sv
// Captures the power-of-3 generator output, checks it against a tracked
// expected value and streams the samples out through a small FIFO.
module pow3_capture #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  output logic              gen_rst,
  output logic              gen_en,
  input  logic [DATA_W-1:0] gen_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [AW:0]       r_count;
  logic [CNT_W-1:0]  r_num;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_errcnt;
  logic [DATA_W-1:0] r_exp;
  logic              r_err;

  logic              w_start;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_last;

  assign w_start   = start &&
                     (r_state == S_IDLE || r_state == S_DONE);
  assign w_push    = gen_en;
  assign m_valid   = (r_count != '0);
  assign w_pop     = m_valid && m_ready;
  assign m_data    = r_mem[r_rp];
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_last    = (w_cnt_nxt == r_num);
  assign err       = r_err;
  assign err_count = r_errcnt;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next state and generator/status controls
  always_comb begin
    w_next  = r_state;
    gen_rst = 1'b0;
    gen_en  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start)
          w_next = (num_samples == '0) ? S_DONE : S_SYNC;
      end
      S_SYNC: begin
        gen_rst = 1'b1;
        w_next  = S_RUN;
      end
      S_RUN: begin
        gen_en = (r_count < FULL);
        if (gen_en && w_last)
          w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_count == '0 || (r_count == 1 && w_pop))
          w_next = S_DONE;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start)
          w_next = (num_samples == '0) ? S_DONE : S_SYNC;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // run bookkeeping: sample count, expected value, error tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num    <= '0;
      r_cnt    <= '0;
      r_exp    <= DATA_W'(1);
      r_err    <= 1'b0;
      r_errcnt <= '0;
    end else begin
      if (w_start) begin
        r_num    <= num_samples;
        r_cnt    <= '0;
        r_err    <= 1'b0;
        r_errcnt <= '0;
      end
      if (gen_rst)
        r_exp <= DATA_W'(1);
      if (w_push) begin
        r_cnt <= w_cnt_nxt;
        r_exp <= r_exp + (r_exp << 1);
        if (gen_data != r_exp) begin
          r_err <= 1'b1;
          if (r_errcnt != '1)
            r_errcnt <= r_errcnt + 1'b1;
        end
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wp] <= gen_data;
  end

endmodule

// File: doc/pow3_capture.md
# pow3_capture

Downstream consumer of the power-of-3 sequence generator. Drives the generator's `rst` and `enable` inputs and captures `power_of_3` on every enabled cycle. Checks each sample against an internally tracked expected value and buffers samples in a small FIFO. Presents the buffered samples on a valid/ready stream, running for a programmable number of samples per run.

## Interface
- `DATA_W`, default 32: sample width; must match the generator's `data_size`.
- `DEPTH`, default 8: FIFO entries; power of two, 2 or more.
- `CNT_W`, default 16: width of sample-count and error-count fields.

Ports:
- `clk` in, 1: clock.
- `rst` in, 1: reset, synchronous, active-high.
- `start` in, 1: begin a run; sampled only in IDLE or DONE.
- `num_samples` in, CNT_W: samples to capture; latched when `start` is accepted.
- `gen_rst` out, 1: drives the generator's `rst`.
- `gen_en` out, 1: drives the generator's `enable`.
- `gen_data` in, DATA_W: the generator's `power_of_3`.
- `m_valid` out, 1: FIFO head is valid.
- `m_data` out, DATA_W: FIFO head.
- `m_ready` in, 1: sink accepts the head.
- `busy` out, 1: state is not IDLE and not DONE.
- `done` out, 1: high while in DONE.
- `err` out, 1: sticky mismatch flag; cleared on `rst` or an accepted `start`.
- `err_count` out, CNT_W: mismatch count; saturates at all-ones; cleared like `err`.

## Operation
- States: IDLE, SYNC, RUN, DRAIN, DONE. Reset enters IDLE.
- IDLE or DONE with `start`=1:
  - If the latched `num_samples`=0, go to DONE.
  - Otherwise go to SYNC.
  - In both cases, clear `err`, `err_count` and the sample counter.
- SYNC, one cycle:
  - `gen_rst`=1, so the generator loads 1 at this edge.
  - The expected register loads 1.
  - Next state is RUN.
- RUN:
  - `gen_en` = (FIFO count < DEPTH), combinational from registered count. Asserted only in RUN.
  - On each edge with `gen_en`=1:
    - Push `gen_data` into the FIFO.
    - Compare `gen_data` with the expected value. On mismatch, set `err` and increment `err_count`.
    - Update expected to expected*3, truncated to DATA_W bits (mod 2^DATA_W).
    - Increment the sample counter.
  - When the push that reaches `num_samples` occurs, go to DRAIN. No further `gen_en`.
- DRAIN: when the FIFO count reaches 0, go to DONE.
- DONE: `done`=1; hold until `start`.
- Stream output:
  - `m_valid` = (count != 0).
  - `m_data` = head entry, read combinationally from registered storage.
  - A pop occurs when `m_valid` and `m_ready` are both 1.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full FIFO: `gen_en`=0, even if a pop happens that cycle. The push resumes the following cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- `start` while in SYNC, RUN or DRAIN is ignored.
- `rst` mid-run:
  - State returns to IDLE and the FIFO empties.
  - All outputs return to their reset values. Any in-flight samples are discarded.

## Timing
- Reset values:
  - `gen_rst`=0, `gen_en`=0, `m_valid`=0, `busy`=0, `done`=0, `err`=0, `err_count`=0.
  - `m_data` is don't-care while `m_valid`=0.
- `start` accepted at edge T:
  - SYNC during cycle T+1, with `gen_rst`=1.
  - RUN from T+2, with `gen_en`=1 when not full.
  - First push at the end of cycle T+2, value 1.
- Capture latency: a push at edge E gives `m_valid`=1 from cycle E+1.
- With the sink always ready, samples 1, 3, 9, 27, … appear on consecutive cycles, one per clock.
- Last push at edge L: DRAIN from L+1.
- Last pop at edge P: `done`=1 from P+1.
- With `num_samples`=0: `start` at T gives `done`=1 at T+1, with no `gen_rst` and no `gen_en`.

## Test plan
- Run of 5 samples, `m_ready`=1 constantly → stream 1, 3, 9, 27, 81 on consecutive cycles; `err`=0; `done` one cycle after the last pop.
- DATA_W=8, run of 7 samples → 1, 3, 9, 27, 81, 243, 217 (729 mod 256); no error flagged.
- `m_ready`=0 for 20 cycles, DEPTH=8, run of 12 samples:
  - Exactly 8 pushes occur, then `gen_en`=0.
  - Releasing `m_ready` delivers all 12 samples in order with no loss.
- Bench forces `gen_data`=5 in place of 9 on the third sample:
  - `err`=1 and `err_count`=1.
  - The subsequent samples 27 and 81 still count as matches, because expected advances independently of `gen_data`.
- Assert `rst` while in RUN with 3 samples buffered → next cycle IDLE, `m_valid`=0, `gen_en`=0; a new `start` yields a fresh stream beginning at 1.
- `start` with `num_samples`=0 → `done`=1 next cycle, with `gen_rst` and `gen_en` never asserted. `start` asserted during RUN is ignored, and the run completes with its original count.
